// File: rtl/addsub_pkg.sv
// Shared encodings for the digit-serial adder/subtractor.
package addsub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/addsub_slice.sv
// Combinational DIGIT-bit ripple of 1-bit add/sub cells.
// The chain bit is a carry in add mode and a borrow in sub mode.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             chain_in,
  input  logic             mode,
  output logic [DIGIT-1:0] s,
  output logic             chain_out
);
  logic w_c;

  // Ripple the chain bit LSB to MSB through the digit.
  always_comb begin
    w_c = chain_in;
    s   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ w_c;
      if (mode == MODE_SUB)
        w_c = (~x[i] & y[i]) | (~x[i] & w_c) | (y[i] & w_c);
      else
        w_c = (x[i] & y[i]) | ((x[i] ^ y[i]) & w_c);
    end
    chain_out = w_c;
  end
endmodule

// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, start/done handshake.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, w_acc_nxt, r_result;
  logic             r_mode, r_chain, r_cout, r_ovf, r_zero;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_x, w_y, w_s;
  logic             w_chain_out, w_last, w_ovf;

  addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .x        (w_x),
    .y        (w_y),
    .chain_in (r_chain),
    .mode     (r_mode),
    .s        (w_s),
    .chain_out(w_chain_out)
  );

  // Select the current digit and merge the slice output into the partial result.
  always_comb begin
    w_x       = r_a[r_cnt*DIGIT +: DIGIT];
    w_y       = r_b[r_cnt*DIGIT +: DIGIT];
    w_acc_nxt = r_acc;
    w_acc_nxt[r_cnt*DIGIT +: DIGIT] = w_s;
    w_last    = (r_cnt == LAST);
    if (r_mode == MODE_SUB)
      w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_acc_nxt[WIDTH-1] != r_a[WIDTH-1]);
    else
      w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_acc_nxt[WIDTH-1] != r_a[WIDTH-1]);
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last digit, DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, digit stepping and result/flag commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mode   <= MODE_ADD;
      r_chain  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_chain <= cin;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_nxt;
          r_chain <= w_chain_out;
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_cout   <= w_chain_out;
            r_ovf    <= w_ovf;
            r_zero   <= (w_acc_nxt == '0);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;
endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench: three configurations (8/2, 16/16, 16/1) against an arithmetic model.
module tb_seq_addsub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic        mode = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [2:0]  busy, done, cout, ovf, zero;
  logic [7:0]  res0;
  logic [15:0] res1, res2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .busy(busy[0]), .done(done[0]), .result(res0), .cout(cout[0]),
    .ovf(ovf[0]), .zero(zero[0]));
  seq_addsub #(.WIDTH(16), .DIGIT(16)) u16w (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode), .a(a), .b(b),
    .cin(cin), .busy(busy[1]), .done(done[1]), .result(res1), .cout(cout[1]),
    .ovf(ovf[1]), .zero(zero[1]));
  seq_addsub #(.WIDTH(16), .DIGIT(1)) u16s (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode), .a(a), .b(b),
    .cin(cin), .busy(busy[2]), .done(done[2]), .result(res2), .cout(cout[2]),
    .ovf(ovf[2]), .zero(zero[2]));

  function automatic int n_of(int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 16;
  endfunction

  function automatic int w_of(int s);
    return (s == 0) ? 8 : 16;
  endfunction

  function automatic logic [15:0] res_of(int s);
    case (s)
      0:       return {8'h00, res0};
      1:       return res1;
      default: return res2;
    endcase
  endfunction

  // Reference: plain integer arithmetic; returns {cout, ovf, zero, result}.
  function automatic logic [18:0] model(int w, bit m, logic [15:0] av, logic [15:0] bv, bit c);
    longint mask = (longint'(1) << w) - 1;
    longint ua = longint'(av) & mask;
    longint ub = longint'(bv) & mask;
    longint full;
    logic [15:0] r;
    bit co, ov, am, bm, rm;
    if (!m) begin
      full = ua + ub + longint'(c);
      co   = ((full >> w) & 1) != 0;
    end else begin
      full = ua - ub - longint'(c);
      co   = ua < (ub + longint'(c));
    end
    r  = 16'(full & mask);
    am = av[w-1];
    bm = bv[w-1];
    rm = r[w-1];
    ov = m ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
    return {co, ov, (r == 16'h0), r};
  endfunction

  // One transaction on instance s; noisy re-pulses start with junk operands while busy.
  task automatic do_op(input int s, input bit m, input logic [15:0] av, input logic [15:0] bv,
                       input bit c, input bit noisy);
    int n = n_of(s);
    logic [15:0] msk = (w_of(s) == 8) ? 16'h00FF : 16'hFFFF;
    logic [18:0] exp;
    logic [18:0] got;
    exp = model(w_of(s), m, av & msk, bv & msk, c);
    @(negedge clk);
    a = av; b = bv; mode = m; cin = c; start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    checks++;
    if (busy[s] !== 1'b1 || done[s] !== 1'b0) begin
      errors++;
      $display("FAIL accept s=%0d busy=%b done=%b want busy=1 done=0", s, busy[s], done[s]);
    end
    for (int e = 1; e <= n; e++) begin
      if (noisy) begin
        a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom); cin = 1'($urandom);
        start[s] = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (done[s] !== (e == n)) begin
        errors++;
        $display("FAIL done_timing s=%0d edge k+%0d done=%b want %b", s, e, done[s], (e == n));
      end
    end
    start[s] = 1'b0;
    got = {cout[s], ovf[s], zero[s], res_of(s)};
    checks++;
    if (got !== exp || busy[s] !== 1'b1) begin
      errors++;
      $display("FAIL result s=%0d m=%0d a=%h b=%h cin=%0d got c/o/z/r=%b%b%b/%h busy=%b want %b%b%b/%h busy=1",
               s, m, av & msk, bv & msk, c, got[18], got[17], got[16], got[15:0], busy[s],
               exp[18], exp[17], exp[16], exp[15:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (done[s] !== 1'b0 || busy[s] !== 1'b0 || res_of(s) !== exp[15:0]) begin
      errors++;
      $display("FAIL return_idle s=%0d done=%b busy=%b res=%h want 0 0 %h",
               s, done[s], busy[s], res_of(s), exp[15:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({busy[s], done[s], cout[s], ovf[s], zero[s], res_of(s)} !== 21'h0) begin
        errors++;
        $display("FAIL reset s=%0d busy=%b done=%b c=%b o=%b z=%b res=%h want all 0",
                 s, busy[s], done[s], cout[s], ovf[s], zero[s], res_of(s));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op(0, 1'b1, 16'h35, 16'h12, 1'b0, 1'b0);
    do_op(0, 1'b1, 16'h12, 16'h35, 1'b0, 1'b0);
    do_op(0, 1'b1, 16'h80, 16'h01, 1'b0, 1'b0);
    do_op(0, 1'b0, 16'hFF, 16'h01, 1'b0, 1'b0);
    do_op(0, 1'b0, 16'h7F, 16'h01, 1'b0, 1'b0);
    do_op(0, 1'b0, 16'hFF, 16'h00, 1'b1, 1'b0);
    do_op(0, 1'b1, 16'h00, 16'h00, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_op(0, 1'b1, 16'h35, 16'h12, 1'b0, 1'b1);
    do_op(2, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    do_op(0, 1'b0, 16'h7F, 16'h01, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h12; b = 16'h35; mode = 1'b1; cin = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || res0 !== 8'h00 || cout[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort s=0 busy=%b done=%b res=%h c=%b o=%b want all 0",
               busy[0], done[0], res0, cout[0], ovf[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done[0] !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done saw done=1 want 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 1'b1, 16'h35, 16'h12, 1'b0, 1'b0);
  endtask

  task automatic test_wide_digit();
    do_op(1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0);
    do_op(1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(2, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0);
    do_op(2, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 15; i++)
        do_op(s, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_wide_digit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
